// File: rtl/param_reg_file.sv
// NUM_REGS x WIDTH register file: broadcast load/clear/inc/dec, two combinational read ports.
// Write->read 1 cycle (0 with BYPASS), WrapEvt 1 cycle after the wrapping/clamping edge.
module param_reg_file #(
  parameter int               WIDTH     = 8,
  parameter int               NUM_REGS  = 4,
  parameter int               SELW      = $clog2(NUM_REGS),
  parameter bit               SATURATE  = 1'b0,
  parameter bit               BYPASS    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          FunSel,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SELW-1:0]     OutASel,
  input  logic [SELW-1:0]     OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] Zero,
  output logic                WrapEvt
);

  typedef enum logic [1:0] {
    FUN_DEC  = 2'b00,
    FUN_INC  = 2'b01,
    FUN_LOAD = 2'b10,
    FUN_CLR  = 2'b11
  } fun_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] reg_q [NUM_REGS];
  logic [WIDTH-1:0] reg_d [NUM_REGS];
  logic             wrap_q;
  logic             wrap_d;

  always_comb begin
    wrap_d = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_d[k] = reg_q[k];
      if (RegSel[k]) begin
        case (fun_e'(FunSel))
          FUN_LOAD: reg_d[k] = I;
          FUN_CLR:  reg_d[k] = '0;
          FUN_INC: begin
            if (reg_q[k] == ALL_ONES) begin
              wrap_d   = 1'b1;
              reg_d[k] = SATURATE ? ALL_ONES : '0;
            end else begin
              reg_d[k] = reg_q[k] + ONE;
            end
          end
          default: begin
            // FUN_DEC: the boundary is zero; clamping holds it there.
            if (reg_q[k] == '0) begin
              wrap_d   = 1'b1;
              reg_d[k] = SATURATE ? '0 : ALL_ONES;
            end else begin
              reg_d[k] = reg_q[k] - ONE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_q[k] <= RESET_VAL;
      end
      wrap_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_q[k] <= reg_d[k];
      end
      wrap_q <= wrap_d;
    end
  end

  // Unselected registers have reg_d == reg_q, so bypass only changes selected ones.
  assign OutA    = BYPASS ? reg_d[OutASel] : reg_q[OutASel];
  assign OutB    = BYPASS ? reg_d[OutBSel] : reg_q[OutBSel];
  assign WrapEvt = wrap_q;

  always_comb begin
    Zero = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      Zero[k] = (reg_q[k] == '0);
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench: a wrapping/non-bypass file and a saturating/bypass file driven in lockstep.
module tb_param_reg_file;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] FunSel;
  logic [3:0] RegSel;
  logic [7:0] I;
  logic [1:0] OutASel;
  logic [1:0] OutBSel;

  logic [7:0] a_w, b_w, a_s, b_s;
  logic [3:0] z_w, z_s;
  logic       e_w, e_s;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  param_reg_file #(.WIDTH(8), .NUM_REGS(4), .SATURATE(1'b0), .BYPASS(1'b0)) dut_w (
    .Clock(Clock), .Reset(Reset), .FunSel(FunSel), .RegSel(RegSel), .I(I),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(a_w), .OutB(b_w), .Zero(z_w), .WrapEvt(e_w)
  );

  param_reg_file #(.WIDTH(8), .NUM_REGS(4), .SATURATE(1'b1), .BYPASS(1'b1)) dut_s (
    .Clock(Clock), .Reset(Reset), .FunSel(FunSel), .RegSel(RegSel), .I(I),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(a_s), .OutB(b_s), .Zero(z_s), .WrapEvt(e_s)
  );

  typedef struct {
    logic [1:0] fun;
    logic [3:0] sel;
    logic [7:0] din;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [7:0] xa_w;
    logic [7:0] xb_w;
    logic [3:0] xz_w;
    logic       xe_w;
    logic [7:0] xa_s;
    logic [7:0] xb_s;
    logic [3:0] xz_s;
    logic       xe_s;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation, clock it, then park RegSel at 0 so bypass does not mask the stored value.
  task automatic step(input logic [1:0] fun, input logic [3:0] sel, input logic [7:0] din,
                      input logic [1:0] asel, input logic [1:0] bsel);
    FunSel  = fun;
    RegSel  = sel;
    I       = din;
    OutASel = asel;
    OutBSel = bsel;
    @(posedge Clock);
    #1 RegSel = 4'b0000;
    #1;
  endtask

  initial begin
    //             fun    sel      din    a  b   a_w    b_w    z_w      e_w   a_s    b_s    z_s      e_s
    vecs[0] = '{2'b10, 4'b0101, 8'hE4, 0, 1, 8'hE4, 8'h00, 4'b1010, 1'b0, 8'hE4, 8'h00, 4'b1010, 1'b0};
    vecs[1] = '{2'b10, 4'b0001, 8'hFF, 0, 2, 8'hFF, 8'hE4, 4'b1010, 1'b0, 8'hFF, 8'hE4, 4'b1010, 1'b0};
    vecs[2] = '{2'b01, 4'b0001, 8'h00, 0, 0, 8'h00, 8'h00, 4'b1011, 1'b1, 8'hFF, 8'hFF, 4'b1010, 1'b1};
    vecs[3] = '{2'b01, 4'b0000, 8'h00, 0, 2, 8'h00, 8'hE4, 4'b1011, 1'b0, 8'hFF, 8'hE4, 4'b1010, 1'b0};
    vecs[4] = '{2'b11, 4'b0100, 8'h00, 2, 2, 8'h00, 8'h00, 4'b1111, 1'b0, 8'h00, 8'h00, 4'b1110, 1'b0};
    vecs[5] = '{2'b00, 4'b0100, 8'h00, 2, 1, 8'hFF, 8'h00, 4'b1011, 1'b1, 8'h00, 8'h00, 4'b1110, 1'b1};
    vecs[6] = '{2'b10, 4'b0100, 8'h6D, 2, 3, 8'h6D, 8'h00, 4'b1011, 1'b0, 8'h6D, 8'h00, 4'b1010, 1'b0};
    vecs[7] = '{2'b00, 4'b0100, 8'h00, 2, 2, 8'h6C, 8'h6C, 4'b1011, 1'b0, 8'h6C, 8'h6C, 4'b1010, 1'b0};
    vecs[8] = '{2'b01, 4'b1010, 8'h00, 1, 3, 8'h01, 8'h01, 4'b0001, 1'b0, 8'h01, 8'h01, 4'b0000, 1'b0};
    vecs[9] = '{2'b10, 4'b1111, 8'h80, 0, 3, 8'h80, 8'h80, 4'b0000, 1'b0, 8'h80, 8'h80, 4'b0000, 1'b0};

    Reset   = 1'b0;
    FunSel  = 2'b00;
    RegSel  = 4'b0000;
    I       = 8'h00;
    OutASel = 2'd0;
    OutBSel = 2'd1;
    @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    check("reset OutA w", a_w, 8'h00);
    check("reset OutB w", b_w, 8'h00);
    check("reset Zero w", z_w, 4'b1111);
    check("reset WrapEvt w", e_w, 1'b0);
    check("reset OutA s", a_s, 8'h00);
    check("reset OutB s", b_s, 8'h00);
    check("reset Zero s", z_s, 4'b1111);
    check("reset WrapEvt s", e_s, 1'b0);

    for (int v = 0; v < 10; v++) begin
      step(vecs[v].fun, vecs[v].sel, vecs[v].din, vecs[v].asel, vecs[v].bsel);
      check($sformatf("vec%0d OutA w", v), a_w, vecs[v].xa_w);
      check($sformatf("vec%0d OutB w", v), b_w, vecs[v].xb_w);
      check($sformatf("vec%0d Zero w", v), z_w, vecs[v].xz_w);
      check($sformatf("vec%0d WrapEvt w", v), e_w, vecs[v].xe_w);
      check($sformatf("vec%0d OutA s", v), a_s, vecs[v].xa_s);
      check($sformatf("vec%0d OutB s", v), b_s, vecs[v].xb_s);
      check($sformatf("vec%0d Zero s", v), z_s, vecs[v].xz_s);
      check($sformatf("vec%0d WrapEvt s", v), e_s, vecs[v].xe_s);
    end

    // Bypass: before the edge only the bypassing file shows the value being loaded.
    OutASel = 2'd3;
    OutBSel = 2'd3;
    FunSel  = 2'b10;
    I       = 8'h6D;
    RegSel  = 4'b1000;
    #1;
    check("bypass pre-edge OutA s", a_s, 8'h6D);
    check("bypass pre-edge OutB s", b_s, 8'h6D);
    check("no-bypass pre-edge OutA w", a_w, 8'h80);
    @(posedge Clock);
    #1 RegSel = 4'b0000;
    #1;
    check("post-edge OutA w", a_w, 8'h6D);
    check("post-edge OutA s", a_s, 8'h6D);

    // Increment at all-ones on several registers at once: wrap vs clamp, single-cycle pulse.
    step(2'b10, 4'b0011, 8'hFF, 0, 1);
    step(2'b01, 4'b0011, 8'h00, 0, 1);
    check("multi inc OutA w", a_w, 8'h00);
    check("multi inc OutB w", b_w, 8'h00);
    check("multi inc OutA s", a_s, 8'hFF);
    check("multi inc WrapEvt w", e_w, 1'b1);
    check("multi inc WrapEvt s", e_s, 1'b1);
    @(posedge Clock);
    #2;
    check("pulse drop WrapEvt w", e_w, 1'b0);
    check("pulse drop WrapEvt s", e_s, 1'b0);

    // Reset concurrent with an increment discards the increment.
    step(2'b10, 4'b1111, 8'h55, 1, 2);
    check("load55 OutA w", a_w, 8'h55);
    check("load55 OutB s", b_s, 8'h55);
    FunSel = 2'b01;
    RegSel = 4'b1111;
    Reset  = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b1;
    RegSel = 4'b0000;
    #1;
    check("mid reset OutA w", a_w, 8'h00);
    check("mid reset OutB w", b_w, 8'h00);
    check("mid reset Zero w", z_w, 4'b1111);
    check("mid reset WrapEvt w", e_w, 1'b0);
    check("mid reset OutA s", a_s, 8'h00);
    check("mid reset Zero s", z_s, 4'b1111);
    check("mid reset WrapEvt s", e_s, 1'b0);

    // Decrement from zero right after reset wraps/clamps and pulses.
    step(2'b00, 4'b0100, 8'h00, 2, 2);
    check("dec0 OutA w", a_w, 8'hFF);
    check("dec0 OutA s", a_s, 8'h00);
    check("dec0 WrapEvt w", e_w, 1'b1);
    check("dec0 WrapEvt s", e_s, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
